// File: rtl/lif_array.sv
// Array of independent leaky integrate-and-fire neurons.
// Shared threshold, per-channel refractory counters, saturating spike total.
module lif_array #(
    parameter int N_CH       = 4,
    parameter int W          = 8,
    parameter int LEAK_SHIFT = 1,
    parameter int REFRAC     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                step,
    input  logic [N_CH*W-1:0]   current,
    input  logic [W-1:0]        threshold,
    input  logic                clr_cnt,
    output logic [N_CH-1:0]     spike,
    output logic [N_CH*W-1:0]   state,
    output logic [N_CH-1:0]     refrac_busy,
    output logic [15:0]         spike_total
);

    localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
    localparam logic [RW-1:0] R_LOAD = RW'(REFRAC);

    logic [N_CH*W-1:0]       state_q, state_d;
    logic [N_CH-1:0][RW-1:0] r_q, r_d;
    logic [N_CH-1:0]         spike_q, spike_d;
    logic [N_CH-1:0]         busy_q, busy_d;
    logic [15:0]             total_q, total_d;

    // Per-channel integrate / leak / fire / refractory update.
    always_comb begin
        logic [W-1:0] s;
        logic [W-1:0] cur;
        logic [W:0]   raw;
        logic [W-1:0] sat;
        state_d = state_q;
        r_d     = r_q;
        spike_d = '0;
        s       = '0;
        cur     = '0;
        raw     = '0;
        sat     = '0;
        for (int i = 0; i < N_CH; i++) begin
            s   = state_q[i*W +: W];
            cur = current[i*W +: W];
            raw = {1'b0, s} - {1'b0, (s >> LEAK_SHIFT)} + {1'b0, cur};
            sat = raw[W] ? {W{1'b1}} : raw[W-1:0];
            if (step) begin
                if (r_q[i] != '0) begin
                    state_d[i*W +: W] = '0;
                    r_d[i]            = r_q[i] - 1'b1;
                end else if (sat >= threshold) begin
                    state_d[i*W +: W] = '0;
                    r_d[i]            = R_LOAD;
                    spike_d[i]        = 1'b1;
                end else begin
                    state_d[i*W +: W] = sat;
                end
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            busy_d[i] = (r_d[i] != '0);
        end
    end

    // Saturating spike counter; a clear discards spikes of the same cycle.
    always_comb begin
        logic [16:0] sum;
        sum = {1'b0, total_q};
        for (int i = 0; i < N_CH; i++) begin
            sum = sum + 17'(spike_d[i]);
        end
        if (clr_cnt) begin
            total_d = '0;
        end else if (sum[16]) begin
            total_d = 16'hFFFF;
        end else begin
            total_d = sum[15:0];
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= '0;
            r_q     <= '0;
            spike_q <= '0;
            busy_q  <= '0;
            total_q <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            spike_q <= spike_d;
            busy_q  <= busy_d;
            total_q <= total_d;
        end
    end

    assign spike       = spike_q;
    assign state       = state_q;
    assign refrac_busy = busy_q;
    assign spike_total = total_q;

endmodule

// File: tb/tb_lif_array.sv
// Directed bench for lif_array (N_CH=4, W=8, LEAK_SHIFT=1, REFRAC=2).
// Expected values are hand-computed from the leak/fire equations.
module tb_lif_array;

    logic        clk;
    logic        rst_n;
    logic        step;
    logic [31:0] current;
    logic [7:0]  threshold;
    logic        clr_cnt;
    logic [3:0]  spike;
    logic [31:0] state;
    logic [3:0]  refrac_busy;
    logic [15:0] spike_total;

    int n_cmp;
    int n_bad;

    lif_array #(
        .N_CH(4), .W(8), .LEAK_SHIFT(1), .REFRAC(2)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .step(step),
        .current(current),
        .threshold(threshold),
        .clr_cnt(clr_cnt),
        .spike(spike),
        .state(state),
        .refrac_busy(refrac_busy),
        .spike_total(spike_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)",
                     tag, got, got, exp, exp);
        end
    endtask

    function automatic logic [31:0] ch(input int i);
        return 32'(state[i*8 +: 8]);
    endfunction

    task automatic do_step();
        step = 1'b1;
        @(posedge clk);
        #1;
        step = 1'b0;
    endtask

    int exp_a [7] = '{100, 150, 175, 188, 194, 197, 199};

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        step      = 1'b0;
        current   = '0;
        threshold = 8'd200;
        clr_cnt   = 1'b0;
        #12;
        chk("rst_state", state, 0);
        chk("rst_spike", 32'(spike), 0);
        chk("rst_busy", 32'(refrac_busy), 0);
        chk("rst_total", 32'(spike_total), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ch0 integrates current 100 up to threshold 200
        current = {8'd0, 8'd0, 8'd0, 8'd100};
        for (int k = 0; k < 7; k++) begin
            do_step();
            chk($sformatf("a_st%0d", k + 1), ch(0), 32'(exp_a[k]));
            chk($sformatf("a_sp%0d", k + 1), 32'(spike), 0);
        end
        do_step();
        chk("a_fire_sp", 32'(spike), 32'h1);
        chk("a_fire_st", ch(0), 0);
        chk("a_fire_tot", 32'(spike_total), 1);
        chk("a_fire_busy", 32'(refrac_busy), 32'h1);
        chk("a_other", state[31:8], 0);
        @(posedge clk);
        #1;
        chk("a_pulse1", 32'(spike), 0);

        // refractory then refire with current 255
        current = {8'd0, 8'd0, 8'd0, 8'd255};
        do_step();
        chk("b_r1_st", ch(0), 0);
        chk("b_r1_busy", 32'(refrac_busy), 32'h1);
        chk("b_r1_sp", 32'(spike), 0);
        do_step();
        chk("b_r2_st", ch(0), 0);
        chk("b_r2_busy", 32'(refrac_busy), 0);
        do_step();
        chk("b_fire_sp", 32'(spike), 32'h1);
        chk("b_fire_st", ch(0), 0);
        chk("b_fire_tot", 32'(spike_total), 2);

        // ch3 gets 50 while ch0 refractory, then hold with step low
        current = {8'd50, 8'd0, 8'd0, 8'd255};
        do_step();
        chk("c_st", state, 32'h3200_0000);
        current = 32'h5555_5555;
        repeat (10) @(posedge clk);
        #1;
        chk("c_hold_st", state, 32'h3200_0000);
        chk("c_hold_sp", 32'(spike), 0);
        chk("c_hold_busy", 32'(refrac_busy), 32'h1);
        chk("c_hold_tot", 32'(spike_total), 2);

        // saturation: 200 -> 200-100+200=300 -> 255 >= 255
        threshold = 8'd255;
        current   = {8'd0, 8'd0, 8'd200, 8'd0};
        do_step();
        chk("d_st1", ch(1), 200);
        chk("d_busy", 32'(refrac_busy), 0);
        chk("d_st3a", ch(3), 25);
        do_step();
        chk("d_sat_sp", 32'(spike), 32'h2);
        chk("d_sat_st", ch(1), 0);
        chk("d_leak3", ch(3), 13);
        chk("d_tot", 32'(spike_total), 3);

        // threshold 0: every channel fires
        current = '0;
        do_step();
        do_step();
        chk("e_leak3", ch(3), 4);
        threshold = 8'd0;
        do_step();
        chk("e_all_sp", 32'(spike), 32'hF);
        chk("e_all_tot", 32'(spike_total), 7);
        chk("e_all_st", state, 0);
        do_step();
        chk("e_ref_sp", 32'(spike), 0);
        chk("e_ref_busy", 32'(refrac_busy), 32'hF);
        do_step();
        chk("e_ref2_busy", 32'(refrac_busy), 0);
        clr_cnt = 1'b1;
        do_step();
        clr_cnt = 1'b0;
        chk("e_clr_sp", 32'(spike), 32'hF);
        chk("e_clr_tot", 32'(spike_total), 0);

        // build ch0=175 and ch2 refractory, then async reset
        threshold = 8'd200;
        do_step();
        do_step();
        current = {8'd0, 8'd0, 8'd0, 8'd100};
        do_step();
        do_step();
        current = {8'd0, 8'd255, 8'd0, 8'd100};
        do_step();
        chk("f_st0", ch(0), 175);
        chk("f_sp", 32'(spike), 32'h4);
        chk("f_busy", 32'(refrac_busy), 32'h4);
        chk("f_tot", 32'(spike_total), 1);
        #2;
        step  = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("f_rst_st", state, 0);
        chk("f_rst_sp", 32'(spike), 0);
        chk("f_rst_busy", 32'(refrac_busy), 0);
        chk("f_rst_tot", 32'(spike_total), 0);
        step = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        current = {8'd0, 8'd0, 8'd0, 8'd100};
        do_step();
        chk("f_first_st", ch(0), 100);
        chk("f_first_sp", 32'(spike), 0);

        // spike_total saturation: 4 spikes every 3 steps
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n     = 1'b1;
        threshold = 8'd0;
        current   = '0;
        step      = 1'b1;
        repeat (49149) @(posedge clk);
        #1;
        chk("g_pre_sat", 32'(spike_total), 65532);
        repeat (6) @(posedge clk);
        #1;
        chk("g_sat", 32'(spike_total), 65535);
        step = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
